// File: rtl/seg_scan_driver_pkg.sv
// Shared symbol codes, display words and segment bit order for the
// seven-segment scan driver and its decoder.
package seg_scan_driver_pkg;

  typedef logic [4:0] sym_t;
  typedef logic [7:0] seg_t;

  localparam int NUM_DIGITS = 4;

  // Symbol codes 0-9 are the decimal digits themselves.
  localparam sym_t SYM_A     = 5'd10;
  localparam sym_t SYM_B     = 5'd11;
  localparam sym_t SYM_C     = 5'd12;
  localparam sym_t SYM_D     = 5'd13;
  localparam sym_t SYM_E     = 5'd14;
  localparam sym_t SYM_F     = 5'd15;
  localparam sym_t SYM_G     = 5'd16;
  localparam sym_t SYM_O     = 5'd17;
  localparam sym_t SYM_S     = 5'd18;
  localparam sym_t SYM_L     = 5'd19;
  localparam sym_t SYM_P     = 5'd20;
  localparam sym_t SYM_U     = 5'd21;
  localparam sym_t SYM_DASH  = 5'd22;
  localparam sym_t SYM_BLANK = 5'd31;

  // Ready-made 4-digit words, packed {p3,p2,p1,p0}.
  localparam logic [19:0] WORD_BAD  = {SYM_BLANK, SYM_B, SYM_A, SYM_D};
  localparam logic [19:0] WORD_SOSO = {SYM_S, SYM_O, SYM_S, SYM_O};
  localparam logic [19:0] WORD_GOOD = {SYM_G, SYM_O, SYM_O, SYM_D};

  // seg_out bit order is {a,b,c,d,e,f,g,dp}.
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam seg_t SEG_OFF = 8'h00;

  // Builds a segment word from an {a..g} pattern; the decimal point stays dark.
  function automatic seg_t seg_pattern(input logic [6:0] abcdefg);
    return {abcdefg, 1'b0};
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational symbol-code to seven-segment decoder; unknown codes are blank.
module seg_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] segs
);

  // NOTE: assigning the default before the case keeps this purely combinational; no latch.
  always_comb begin
    segs = SEG_OFF;
    case (code)
      5'd0:     segs = seg_pattern(7'b1111110);
      5'd1:     segs = seg_pattern(7'b0110000);
      5'd2:     segs = seg_pattern(7'b1101101);
      5'd3:     segs = seg_pattern(7'b1111001);
      5'd4:     segs = seg_pattern(7'b0110011);
      5'd5:     segs = seg_pattern(7'b1011011);
      5'd6:     segs = seg_pattern(7'b1011111);
      5'd7:     segs = seg_pattern(7'b1110000);
      5'd8:     segs = seg_pattern(7'b1111111);
      5'd9:     segs = seg_pattern(7'b1111011);
      SYM_A:    segs = seg_pattern(7'b1110111);
      SYM_B:    segs = seg_pattern(7'b0011111);
      SYM_C:    segs = seg_pattern(7'b1001110);
      SYM_D:    segs = seg_pattern(7'b0111101);
      SYM_E:    segs = seg_pattern(7'b1001111);
      SYM_F:    segs = seg_pattern(7'b1000111);
      SYM_G:    segs = seg_pattern(7'b1011110);
      SYM_O:    segs = seg_pattern(7'b1111110);
      SYM_S:    segs = seg_pattern(7'b1011011);
      SYM_L:    segs = seg_pattern(7'b0001110);
      SYM_P:    segs = seg_pattern(7'b1100111);
      SYM_U:    segs = seg_pattern(7'b0111110);
      SYM_DASH: segs = seg_pattern(7'b0000001);
      default:  segs = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with tear-free frame updates,
// per-digit anti-ghost blanking and whole-display blink.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int DWELL        = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] p0,
  input  logic [4:0] p1,
  input  logic [4:0] p2,
  input  logic [4:0] p3,
  input  logic       update,
  input  logic       en,
  input  logic       blink,
  output logic [3:0] an,
  output logic [7:0] seg_out,
  output logic       frame_start,
  output logic       update_ack
);

  localparam int DW = $clog2(DWELL);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0] dwell_cnt;
  logic [1:0]    digit_idx;
  logic [FW-1:0] frame_cnt;
  logic          phase;

  sym_t active  [NUM_DIGITS];
  sym_t pending [NUM_DIGITS];
  logic pending_valid;

  logic digit_end;
  logic boundary;
  logic visible;
  sym_t cur_sym;
  seg_t cur_seg;

  always_comb begin
    digit_end = (dwell_cnt == DWELL_LAST);
    boundary  = digit_end && (digit_idx == 2'd3);
    visible   = en && !(blink && phase);
    cur_sym   = active[digit_idx];
  end

  seg_decode u_decode (
    .code (cur_sym),
    .segs (cur_seg)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      digit_idx <= '0;
    end else if (digit_end) begin
      dwell_cnt <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Blink phase advances once per frame; dropping blink restarts it visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (!blink) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  // NOTE: the small symbol arrays are reset so the display powers up blank and stale pending data is dropped.
  // An update on the boundary edge still applies the older pending frame; the new one waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_valid <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i]  <= SYM_BLANK;
        pending[i] <= SYM_BLANK;
      end
    end else begin
      if (boundary && pending_valid) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= pending[i];
      end
      if (update) begin
        pending[0]    <= p0;
        pending[1]    <= p1;
        pending[2]    <= p2;
        pending[3]    <= p3;
        pending_valid <= 1'b1;
      end else if (boundary) begin
        pending_valid <= 1'b0;
      end
    end
  end

  // Dwell count 0 of every digit is the anti-ghost blanking slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '0;
      seg_out     <= '0;
      frame_start <= 1'b0;
      update_ack  <= 1'b0;
    end else begin
      frame_start <= boundary;
      update_ack  <= boundary && pending_valid;
      if ((dwell_cnt != '0) && visible) begin
        an      <= 4'b0001 << digit_idx;
        seg_out <= cur_seg;
      end else begin
        an      <= '0;
        seg_out <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver at DWELL=4, BLINK_FRAMES=2.
module tb_seg_scan_driver;

  localparam int DWELL        = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FL           = 4 * DWELL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] p0, p1, p2, p3;
  logic       update, en, blink;
  logic [3:0] an;
  logic [7:0] seg_out;
  logic       frame_start, update_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] word;   // {p3,p2,p1,p0}
    logic [31:0] segs;   // expected {seg3,seg2,seg1,seg0}
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] prev;

  seg_scan_driver #(
    .DWELL        (DWELL),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0          (p0),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .update      (update),
    .en          (en),
    .blink       (blink),
    .an          (an),
    .seg_out     (seg_out),
    .frame_start (frame_start),
    .update_ack  (update_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full frame starting at a frame_start point, optionally issuing
  // up to two updates at given cycles, and checks every output cycle.
  task automatic run_frame(input string tag, input logic [31:0] segs, input bit vis,
                           input bit ack_end, input int sa, input logic [19:0] wa,
                           input int sb, input logic [19:0] wb);
    int         t, idx, dw;
    logic [3:0] ean;
    logic [7:0] eseg;
    for (int s = 0; s < FL; s++) begin
      if (s == sa) begin
        update = 1'b1;
        {p3, p2, p1, p0} = wa;
      end else if (s == sb) begin
        update = 1'b1;
        {p3, p2, p1, p0} = wb;
      end else begin
        update = 1'b0;
      end
      step();
      t   = s + 1;
      idx = (t - 1) / DWELL;
      dw  = (t - 1) % DWELL;
      if (vis && dw != 0) begin
        ean  = 4'b0001 << idx;
        eseg = segs[idx*8 +: 8];
      end else begin
        ean  = 4'b0000;
        eseg = 8'h00;
      end
      check($sformatf("%s t=%0d an", tag, t), {28'd0, an}, {28'd0, ean});
      check($sformatf("%s t=%0d seg", tag, t), {24'd0, seg_out}, {24'd0, eseg});
      check($sformatf("%s t=%0d frame_start", tag, t), {31'd0, frame_start}, (t == FL) ? 32'd1 : 32'd0);
      check($sformatf("%s t=%0d ack", tag, t), {31'd0, update_ack}, (t == FL) ? {31'd0, ack_end} : 32'd0);
    end
    update = 1'b0;
  endtask

  task automatic sync_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FL && !seen; i++) begin
      step();
      if (frame_start === 1'b1) seen = 1'b1;
    end
    check({tag, " sync"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{{5'd4,  5'd3,  5'd2,  5'd1 }, 32'h66F2DA60};
    vecs[1] = '{{5'd16, 5'd17, 5'd17, 5'd13}, 32'hBCFCFC7A};
    vecs[2] = '{{5'd10, 5'd11, 5'd12, 5'd14}, 32'hEE3E9C9E};
    vecs[3] = '{{5'd20, 5'd19, 5'd21, 5'd22}, 32'hCE1C7C02};
    vecs[4] = '{{5'd5,  5'd6,  5'd7,  5'd8 }, 32'hB6BEE0FE};
    vecs[5] = '{{5'd9,  5'd0,  5'd15, 5'd18}, 32'hF6FC8EB6};
    vecs[6] = '{{5'd23, 5'd30, 5'd31, 5'd24}, 32'h00000000};
    vecs[7] = '{{5'd18, 5'd17, 5'd18, 5'd17}, 32'hB6FCB6FC};
    vecs[8] = '{{5'd29, 5'd0,  5'd8,  5'd3 }, 32'h00FCFEF2};

    rst_n = 1'b0; update = 1'b0; en = 1'b1; blink = 1'b0;
    {p3, p2, p1, p0} = '0;
    repeat (3) step();
    check("reset an", {28'd0, an}, 32'd0);
    check("reset seg", {24'd0, seg_out}, 32'd0);
    check("reset frame_start", {31'd0, frame_start}, 32'd0);
    check("reset ack", {31'd0, update_ack}, 32'd0);
    rst_n = 1'b1;

    // Idle scan: blank symbols, digits still enabled in turn.
    run_frame("idle0", 32'h0, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("idle1", 32'h0, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Table: each frame shows the previous vector while capturing the next.
    prev = 32'h0;
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("vec%0d", i), prev, 1'b1, 1'b1, 6, vecs[i].word, -1, 20'h0);
      prev = vecs[i].segs;
    end
    run_frame("vec_last", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Two updates in one frame: last wins, single ack.
    run_frame("dbl_upd", prev, 1'b1, 1'b1, 3, {5'd31, 5'd31, 5'd31, 5'd1}, 9, {5'd31, 5'd31, 5'd31, 5'd2});
    prev = 32'h000000DA;
    run_frame("dbl_show", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Update on the boundary edge waits one more frame.
    run_frame("edge_upd", prev, 1'b1, 1'b0, FL - 1, vecs[0].word, -1, 20'h0);
    run_frame("edge_wait", prev, 1'b1, 1'b1, -1, 20'h0, -1, 20'h0);
    prev = vecs[0].segs;
    run_frame("edge_show", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Pending frame applies at the boundary while a coincident update queues.
    run_frame("pre_edge", prev, 1'b1, 1'b1, 5, vecs[1].word, FL - 1, vecs[2].word);
    run_frame("pre_show", vecs[1].segs, 1'b1, 1'b1, -1, 20'h0, -1, 20'h0);
    prev = vecs[2].segs;
    run_frame("post_show", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Blink: two visible frames, two dark, alternating.
    blink = 1'b1;
    run_frame("blink_f0", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("blink_f1", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("blink_f2", prev, 1'b0, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("blink_f3", prev, 1'b0, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("blink_f4", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("blink_f5", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Drop blink in the dark phase: visible from the next non-blanking cycle.
    for (int s = 1; s <= 5; s++) begin
      step();
      check($sformatf("blink_dark t=%0d an", s), {28'd0, an}, 32'd0);
    end
    blink = 1'b0;
    step();
    check("blink_drop an", {28'd0, an}, 32'h2);
    check("blink_drop seg", {24'd0, seg_out}, {24'd0, prev[15:8]});
    sync_frame("blink_drop");
    run_frame("after_blink", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Display disabled: outputs dark, frame_start keeps pulsing.
    en = 1'b0;
    run_frame("en_off", prev, 1'b0, 1'b0, -1, 20'h0, -1, 20'h0);
    en = 1'b1;
    run_frame("en_on", prev, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    // Asynchronous reset mid-digit-2 with an update pending.
    for (int s = 0; s < 10; s++) begin
      if (s == 5) begin
        update = 1'b1;
        {p3, p2, p1, p0} = vecs[3].word;
      end else begin
        update = 1'b0;
      end
      step();
    end
    check("pre_rst an", {28'd0, an}, 32'h4);
    check("pre_rst seg", {24'd0, seg_out}, {24'd0, prev[23:16]});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst an", {28'd0, an}, 32'd0);
    check("async_rst seg", {24'd0, seg_out}, 32'd0);
    check("async_rst frame_start", {31'd0, frame_start}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    run_frame("post_rst0", 32'h0, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);
    run_frame("post_rst1", 32'h0, 1'b1, 1'b0, -1, 20'h0, -1, 20'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed 4-digit seven-segment driver. It consumes the 5-bit symbol codes p0..p3 produced by the score-to-level conversion and by other display sources.
- Latches a new frame on an update pulse and applies it only at a frame boundary, so no tearing occurs. Scans digits with a per-digit dwell, inserts an anti-ghost blanking cycle, and supports blink.
- Sits between the game/score logic and the board's segment/anode pins.

Parameters:
- DWELL, 100000: clock cycles per digit, including 1 blanking cycle; minimum 2.
- BLINK_FRAMES, 125: full 4-digit frames per blink half-period.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- p0  in  5  symbol code, rightmost digit (an[0]).
- p1  in  5  symbol code, digit 1.
- p2  in  5  symbol code, digit 2.
- p3  in  5  symbol code, leftmost digit (an[3]).
- update  in  1  one-cycle request to capture p0..p3.
- en  in  1  display enable; 0 blanks outputs, scan keeps running.
- blink  in  1  1 = blink the whole display.
- an  out  4  digit enables, one-hot, active-high.
- seg_out  out  8  {a,b,c,d,e,f,g,dp}, active-high.
- frame_start  out  1  one-cycle pulse on entry to digit 0.
- update_ack  out  1  one-cycle pulse when the pending frame becomes active.

Behaviour:
- Reset (async, rst_n=0):
  - an=0, seg_out=0, frame_start=0, update_ack=0.
  - Dwell counter=0, digit index=0, frame counter=0, blink phase=0 (visible).
  - Active codes all = SYM_BLANK (31); pending flag=0. Release resumes from digit 0, dwell 0.
- Scan:
  - Dwell counter runs 0..DWELL-1. At DWELL-1 the digit index advances 0→1→2→3→0.
  - Wrap 3→0 is the frame boundary; frame_start=1 on the first cycle of digit 0.
- Capture: update=1 copies p0..p3 into pending and sets the pending flag the same edge. Multiple updates before a boundary: last wins.
- Apply:
  - At the boundary edge, if the pending flag is set, pending→active, the flag clears, and update_ack=1 for the first cycle of digit 0.
  - If update coincides with the boundary edge, the pre-edge pending contents (if any) are applied. The new capture stays pending for the next boundary, with its own ack then.
- Outputs are registered from state, i.e. one-cycle latency from index/counter.
  - Dwell count 0 of each digit is a blanking cycle: an=0, seg_out=0.
  - On other counts: an=one-hot(index) and seg_out=decode(active[index]), if visible.
- Visible = en && !(blink && phase).
  - blink=0 holds the frame counter and phase at 0.
  - blink=1: frame counter counts boundaries 0..BLINK_FRAMES-1 and toggles phase on wrap. The first half-period is visible.
- en=0 or invisible: an=0, seg_out=0. Counters, capture and ack continue normally.
- Decode:
  - Codes 0-9 map to digits.
  - 10 A, 11 b, 12 C, 13 d, 14 E, 15 F, 16 G, 17 O, 18 S, 19 L, 20 P, 21 U, 22 '-', 31 blank.
  - 23-30 decode to blank.
  - dp is always 0.

Decomposition:
- Shared constants include:
  - SYM_* codes and SYM_BLANK=31.
  - Word constants BAD, SOSO and GOOD as 20-bit {p3,p2,p1,p0} concatenations.
  - Segment bit-order definition.
- Sub-module seg_decode: combinational 5-bit code → 8-bit segments.
- The driver instantiates one seg_decode on the mux output.

Test Plan:
All scenarios use DWELL=4 and BLINK_FRAMES=2.
1. Reset then release, no update → an cycles 0000 (blank), 0001×3, 0000, 0010×3, …; seg_out=00 throughout; frame_start every 16 cycles.
2. update with p0=1, p1=2, p2=3, p3=4 mid-frame:
   - update_ack fires at the next frame_start, not before.
   - Then digit 0 shows an=0001, seg_out=8'b0110_0000; digit 1 shows an=0010, seg_out=8'b1101_1010.
3. update(p0=1), then update(p0=2) in the same frame → one ack only; digit 0 shows 8'b1101_1010.
4. update asserted on the boundary edge → no ack at this frame_start; ack at the following one; values appear then.
5. blink=1 with valid frame:
   - Visible for 2 frames, then an=0 for 2 frames, alternating.
   - Drop blink during the dark phase → visible from the next non-blanking cycle.
   - en=0 → an=0, seg_out=0 while frame_start keeps pulsing.
6. rst_n low mid-digit-2 with an update pending → an/seg_out go 0 immediately, without waiting for a clock edge. After release there is no ack and the display is blank (pending discarded).
